// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: serial double-dabble binary-to-BCD with 7-segment encode.
// Ports: clk, rst (sync, active-high), start/bin_in in; busy, done, overflow,
//        bcd_out (4 bits per digit), seg_out (7 active-low bits per digit) out.
module bcd_seq_converter #(
    parameter int IN_WIDTH = 10,
    parameter int DIGITS   = 4,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // 10**DIGITS needs up to 34 bits, so compare in 64 bits.
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Walk from the top digit down; a digit stays dark until some
    // non-zero digit at or above it has been seen. Digit 0 always lights.
    function automatic logic [SW-1:0] encode(input logic [BW-1:0] b);
        logic [SW-1:0] s;
        logic          lit;
        s   = '0;
        lit = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (b[4*k +: 4] != 4'd0 || k == 0) begin
                lit = 1'b1;
            end
            if (LZ_BLANK && !lit) begin
                s[7*k +: 7] = 7'b1111111;
            end else begin
                s[7*k +: 7] = glyph(b[4*k +: 4]);
            end
        end
        return s;
    endfunction

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]         scratch_q, scratch_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovp_q, ovp_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [BW-1:0]         bcd_q, bcd_d;
    logic [SW-1:0]         seg_q, seg_d;
    logic [BW-1:0]         adj;

    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovp_d     = ovp_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        seg_d     = seg_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CW'(IN_WIDTH);
                    ovp_d     = 64'(bin_in) >= LIMIT;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // MSB of the top digit falls off: result is mod 10**DIGITS.
                {scratch_d, shreg_d} = {adj[BW-2:0], shreg_q, 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ovf_d   = ovp_q;
                    bcd_d   = scratch_d;
                    seg_d   = encode(scratch_d);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovp_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            seg_q     <= encode('0);
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovp_q     <= ovp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            seg_q     <= seg_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;
    assign seg_out  = seg_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: random and directed checks of bcd_seq_converter
// against an arithmetic decimal/glyph model (three parameter sets).
module tb_bcd_seq_converter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  start;
    logic [9:0]  bin [3];
    logic [2:0]  busy, done, ovf;
    logic [15:0] bcd0, bcd2;
    logic [7:0]  bcd1;
    logic [27:0] seg0, seg2;
    logic [13:0] seg1;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_seq_converter #(.IN_WIDTH(10), .DIGITS(4), .LZ_BLANK(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .bin_in(bin[0]),
        .busy(busy[0]), .done(done[0]), .overflow(ovf[0]),
        .bcd_out(bcd0), .seg_out(seg0)
    );
    bcd_seq_converter #(.IN_WIDTH(10), .DIGITS(2), .LZ_BLANK(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .bin_in(bin[1]),
        .busy(busy[1]), .done(done[1]), .overflow(ovf[1]),
        .bcd_out(bcd1), .seg_out(seg1)
    );
    bcd_seq_converter #(.IN_WIDTH(10), .DIGITS(4), .LZ_BLANK(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .bin_in(bin[2]),
        .busy(busy[2]), .done(done[2]), .overflow(ovf[2]),
        .bcd_out(bcd2), .seg_out(seg2)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned p10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] glyph(input longint unsigned d);
        logic [6:0] tbl [10];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100};
        return tbl[d];
    endfunction

    function automatic int nd_of(input int u);
        return (u == 1) ? 2 : 4;
    endfunction

    function automatic logic [63:0] m_bcd(input longint unsigned v, input int nd);
        logic [63:0] r = '0;
        for (int k = 0; k < nd; k++)
            r = r | (64'((v / p10(k)) % 10) << (4 * k));
        return r;
    endfunction

    function automatic logic [63:0] m_seg(input longint unsigned v, input int nd,
                                          input bit lz);
        logic [63:0]     r = '0;
        longint unsigned m = v % p10(nd);
        logic [6:0]      g;
        for (int k = 0; k < nd; k++) begin
            if (lz && k > 0 && m < p10(k)) g = 7'b1111111;
            else g = glyph((m / p10(k)) % 10);
            r = r | (64'(g) << (7 * k));
        end
        return r;
    endfunction

    function automatic logic [63:0] o_bcd(input int u);
        case (u)
            0: return 64'(bcd0);
            1: return 64'(bcd1);
            default: return 64'(bcd2);
        endcase
    endfunction

    function automatic logic [63:0] o_seg(input int u);
        case (u)
            0: return 64'(seg0);
            1: return 64'(seg1);
            default: return 64'(seg2);
        endcase
    endfunction

    task automatic check_result(input int u, input longint unsigned v);
        check($sformatf("bcd u%0d v%0d", u, v), o_bcd(u), m_bcd(v, nd_of(u)));
        check($sformatf("seg u%0d v%0d", u, v), o_seg(u),
              m_seg(v, nd_of(u), u == 2));
        check($sformatf("ovf u%0d v%0d", u, v), 64'(ovf[u]),
              64'(v >= p10(nd_of(u))));
    endtask

    task automatic conv(input int u, input int unsigned v);
        int n;
        @(negedge clk);
        bin[u]   = v[9:0];
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        n = 1;
        while (!done[u] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("latency u%0d v%0d", u, v), 64'(n), 64'd11);
        check("busy_at_done", 64'(busy[u]), 64'd1);
        check_result(u, v);
        @(negedge clk);
        check("done_pulse", 64'(done[u]), 64'd0);
        check("busy_after", 64'(busy[u]), 64'd0);
    endtask

    task automatic check_reset_state();
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst busy u%0d", u), 64'(busy[u]), 64'd0);
            check($sformatf("rst done u%0d", u), 64'(done[u]), 64'd0);
            check_result(u, 0);
        end
    endtask

    initial begin
        int nd, m, u;
        logic [63:0] got;
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 3; i++) bin[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        conv(0, 987);
        check("hex3_zero", 64'(seg0[27:21]), 64'(7'b0000001));
        conv(0, 1023);
        conv(0, 0);
        conv(1, 1023);
        conv(1, 99);
        conv(1, 100);
        conv(2, 7);
        check("lz_d3", 64'(seg2[27:21]), 64'(7'b1111111));
        check("lz_d0", 64'(seg2[6:0]), 64'(7'b0001111));
        conv(2, 0);
        conv(2, 10);

        // extra starts in SHIFT and DONE must be dropped
        @(negedge clk);
        bin[0]   = 10'd321;
        start[0] = 1'b1;
        @(negedge clk);
        bin[0] = 10'd555;
        nd = 0;
        got = '0;
        for (int c = 1; c < 30; c++) begin
            if (done[0]) begin
                nd++;
                got = 64'(bcd0);
            end
            start[0] = (c == 3 || c == 10 || c == 11);
            @(negedge clk);
        end
        start[0] = 1'b0;
        check("ignored_starts_done", 64'(nd), 64'd1);
        check("ignored_starts_val", got, 64'h0321);
        check("hold_after", 64'(bcd0), 64'h0321);

        // start held high re-triggers on the first IDLE cycle
        @(negedge clk);
        bin[0]   = 10'd250;
        start[0] = 1'b1;
        m = 0;
        while (!done[0] && m < 40) begin
            @(negedge clk);
            m++;
        end
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!done[0] && m < 40);
        start[0] = 1'b0;
        check("retrigger_gap", 64'(m), 64'd12);
        check("retrigger_val", 64'(bcd0), 64'h0250);
        repeat (3) @(negedge clk);

        // reset in the middle of a conversion
        @(negedge clk);
        bin[0]   = 10'd512;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done[0]) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        check("abort_bcd", 64'(bcd0), 64'd0);
        conv(0, 512);

        for (int i = 0; i < 18; i++) begin
            u = int'($urandom_range(0, 2));
            conv(u, $urandom_range(0, 1023));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
